// File: rtl/count_monitor_pkg.sv
// Shared types for the count monitor: FSM states, event codes and the event record.
package count_monitor_pkg;

    // Widest count bus the event record can carry; WIDTH must not exceed this.
    localparam int unsigned EvtValueMax = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StSat   = 2'd2,
        StStall = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EvtStart  = 2'd0,
        EvtSat    = 2'd1,
        EvtStall  = 2'd2,
        EvtResume = 2'd3
    } evt_code_e;

    typedef struct packed {
        evt_code_e              code;
        logic [EvtValueMax-1:0] value;
    } evt_rec_t;

endpackage

// File: rtl/count_monitor_if.sv
// Event handshake between the count monitor and its consumer.
interface count_monitor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_code;
    logic [WIDTH-1:0] evt_value;
    logic             evt_ovf;

    modport master (
        output evt_valid,
        input  evt_ready,
        output evt_code,
        output evt_value,
        output evt_ovf
    );

    modport slave (
        input  evt_valid,
        output evt_ready,
        input  evt_code,
        input  evt_value,
        input  evt_ovf
    );
endinterface

// File: rtl/count_monitor_evt_slot.sv
// One-entry event holding register; a push into a full slot without a transfer is
// dropped and recorded in the sticky overflow flag.
module count_monitor_evt_slot
    import count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  evt_rec_t          rec,
    count_monitor_if.master   evt
);

    logic     valid_q;
    logic     ovf_q;
    evt_rec_t rec_q;
    logic     xfer;

    assign xfer = valid_q && evt.evt_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            rec_q   <= '0;
        end else if (push) begin
            if (!valid_q || xfer) begin
                rec_q   <= rec;
                valid_q <= 1'b1;
            end else begin
                ovf_q   <= 1'b1;
            end
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_code  = rec_q.code;
    assign evt.evt_value = rec_q.value[WIDTH-1:0];
    assign evt.evt_ovf   = ovf_q;

    // Record bits above WIDTH are always zero-extended and never read.
    if (WIDTH < EvtValueMax) begin : g_value_hi
        logic unused_value_hi;
        assign unused_value_hi = ^rec_q.value[EvtValueMax-1:WIDTH];
    end

endmodule

// File: rtl/count_monitor.sv
// Watches an upstream counter: tracks change/wrap statistics and classifies it as
// idle, running, saturated at MAX or stalled, reporting transitions as events.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SAT_HOLD    = 3,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count,
    output logic [1:0]        state,
    output logic              sat_flag,
    output logic              stall_flag,
    output logic [15:0]       change_cnt,
    output logic [7:0]        wrap_cnt,
    count_monitor_if.master   evt
);

    localparam int unsigned SameW = $clog2(STALL_LIMIT + 1);
    localparam logic [SameW-1:0] SatHold    = SameW'(SAT_HOLD);
    localparam logic [SameW-1:0] StallLimit = SameW'(STALL_LIMIT);
    localparam logic [WIDTH-1:0] CountMax   = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [SameW-1:0] same_q, same_next;
    logic             sat_flag_q, stall_flag_q;
    logic [15:0]      change_cnt_q;
    logic [7:0]       wrap_cnt_q;

    logic             chg, is_max, wrap;
    logic             push;
    evt_rec_t         push_rec;

    always_comb begin
        chg       = (count != prev_q);
        is_max    = (count == CountMax);
        wrap      = chg && (prev_q == CountMax) && (count == '0);
        same_next = chg ? '0 : ((same_q == StallLimit) ? same_q : same_q + SameW'(1));

        state_d        = state_q;
        push           = 1'b0;
        push_rec       = '0;
        push_rec.value = EvtValueMax'(count);

        unique case (state_q)
            StIdle: begin
                if (chg) begin
                    state_d       = StRun;
                    push          = 1'b1;
                    push_rec.code = EvtStart;
                end
            end
            StRun: begin
                // Saturation is checked first so a count parked at MAX never stalls.
                if (is_max && same_next >= SatHold) begin
                    state_d       = StSat;
                    push          = 1'b1;
                    push_rec.code = EvtSat;
                end else if (!is_max && same_next >= StallLimit) begin
                    state_d       = StStall;
                    push          = 1'b1;
                    push_rec.code = EvtStall;
                end
            end
            StSat, StStall: begin
                if (chg) begin
                    state_d       = StRun;
                    push          = 1'b1;
                    push_rec.code = EvtResume;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            same_q       <= '0;
            sat_flag_q   <= 1'b0;
            stall_flag_q <= 1'b0;
            change_cnt_q <= '0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= count;
            same_q       <= same_next;
            sat_flag_q   <= (state_d == StSat);
            stall_flag_q <= (state_d == StStall);
            if (chg && change_cnt_q != 16'hFFFF) begin
                change_cnt_q <= change_cnt_q + 16'd1;
            end
            if (wrap && wrap_cnt_q != 8'hFF) begin
                wrap_cnt_q <= wrap_cnt_q + 8'd1;
            end
        end
    end

    count_monitor_evt_slot #(
        .WIDTH (WIDTH)
    ) u_evt_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .rec   (push_rec),
        .evt   (evt)
    );

    assign state      = state_q;
    assign sat_flag   = sat_flag_q;
    assign stall_flag = stall_flag_q;
    assign change_cnt = change_cnt_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: expected events queue up as stimulus is issued and a
// monitor compares them on each handshake; state and counters are checked inline.
module tb_count_monitor;

    typedef struct {
        logic [1:0] code;
        logic [7:0] value;
    } exp_evt_t;

    localparam logic [1:0] CStart  = 2'd0;
    localparam logic [1:0] CSat    = 2'd1;
    localparam logic [1:0] CStall  = 2'd2;
    localparam logic [1:0] CResume = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  count;
    logic [1:0]  state;
    logic        sat_flag;
    logic        stall_flag;
    logic [15:0] change_cnt;
    logic [7:0]  wrap_cnt;

    int checks = 0;
    int errors = 0;
    exp_evt_t exp_q[$];

    count_monitor_if #(.WIDTH(8)) evt_bus ();

    count_monitor #(
        .WIDTH       (8),
        .SAT_HOLD    (3),
        .STALL_LIMIT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count),
        .state      (state),
        .sat_flag   (sat_flag),
        .stall_flag (stall_flag),
        .change_cnt (change_cnt),
        .wrap_cnt   (wrap_cnt),
        .evt        (evt_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [1:0] code, input logic [7:0] value);
        exp_evt_t e;
        e.code  = code;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Apply a count value, let one rising edge sample it, return 1 time unit later.
    task automatic cyc(input logic [7:0] c);
        count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_sat_flag"}, 32'(sat_flag), 32'd0);
        check({tag, "_stall_flag"}, 32'(stall_flag), 32'd0);
        check({tag, "_change_cnt"}, 32'(change_cnt), 32'd0);
        check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'd0);
        check({tag, "_evt_valid"}, 32'(evt_bus.evt_valid), 32'd0);
        check({tag, "_evt_ovf"}, 32'(evt_bus.evt_ovf), 32'd0);
        check({tag, "_evt_code"}, 32'(evt_bus.evt_code), 32'd0);
        check({tag, "_evt_value"}, 32'(evt_bus.evt_value), 32'd0);
    endtask

    // Scoreboard monitor: a record is consumed on the next edge whenever valid && ready.
    always @(negedge clk) begin
        if (evt_bus.evt_valid === 1'b1 && evt_bus.evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0d value %0h expected none",
                         evt_bus.evt_code, evt_bus.evt_value);
            end else begin
                exp_evt_t e;
                e = exp_q.pop_front();
                check("evt_code", 32'(evt_bus.evt_code), 32'(e.code));
                check("evt_value", 32'(evt_bus.evt_value), 32'(e.value));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        count = 8'h00;
        evt_bus.evt_ready = 1'b1;
        cyc(8'h00);
        cyc(8'h00);
        check_cleared("reset");
        rst_n = 1'b1;

        // Constant zero: stays idle, nothing counted.
        for (int i = 0; i < 20; i++) cyc(8'h00);
        check("idle_state", 32'(state), 32'd0);
        check("idle_evt_valid", 32'(evt_bus.evt_valid), 32'd0);
        check("idle_change_cnt", 32'(change_cnt), 32'd0);

        // Ramp to FF then hold: START 01, SAT on third unchanged edge.
        expect_evt(CStart, 8'h01);
        cyc(8'h01);
        check("start_state", 32'(state), 32'd1);
        for (int v = 2; v < 256; v++) cyc(8'(v));
        cyc(8'hFF);
        cyc(8'hFF);
        check("pre_sat_state", 32'(state), 32'd1);
        expect_evt(CSat, 8'hFF);
        cyc(8'hFF);
        check("sat_state", 32'(state), 32'd2);
        check("sat_flag", 32'(sat_flag), 32'd1);
        check("ramp_change_cnt", 32'(change_cnt), 32'd255);

        // FF -> 00 from SAT resumes and counts a wrap.
        expect_evt(CResume, 8'h00);
        cyc(8'h00);
        check("wrap_state", 32'(state), 32'd1);
        check("wrap_cnt", 32'(wrap_cnt), 32'd1);
        check("wrap_sat_flag", 32'(sat_flag), 32'd0);
        check("wrap_change_cnt", 32'(change_cnt), 32'd256);

        // Hold 40 for 16 unchanged edges: STALL, then 41 resumes.
        cyc(8'h40);
        for (int i = 0; i < 15; i++) cyc(8'h40);
        check("pre_stall_state", 32'(state), 32'd1);
        expect_evt(CStall, 8'h40);
        cyc(8'h40);
        check("stall_state", 32'(state), 32'd3);
        check("stall_flag", 32'(stall_flag), 32'd1);
        expect_evt(CResume, 8'h41);
        cyc(8'h41);
        check("resume_state", 32'(state), 32'd1);
        check("resume_stall_flag", 32'(stall_flag), 32'd0);
        check("resume_change_cnt", 32'(change_cnt), 32'd258);
        cyc(8'h41);

        // Overflow: consumer stalled, START held, SAT dropped.
        rst_n = 1'b0;
        cyc(8'h41);
        rst_n = 1'b1;
        evt_bus.evt_ready = 1'b0;
        expect_evt(CStart, 8'hFF);
        cyc(8'hFF);
        cyc(8'hFF);
        cyc(8'hFF);
        cyc(8'hFF);
        check("ovf_state", 32'(state), 32'd2);
        check("ovf_evt_valid", 32'(evt_bus.evt_valid), 32'd1);
        check("ovf_held_code", 32'(evt_bus.evt_code), 32'(CStart));
        check("ovf_held_value", 32'(evt_bus.evt_value), 32'hFF);
        check("ovf_flag", 32'(evt_bus.evt_ovf), 32'd1);

        // Transfer and new RESUME on the same edge: slot reloads.
        evt_bus.evt_ready = 1'b1;
        expect_evt(CResume, 8'h10);
        cyc(8'h10);
        evt_bus.evt_ready = 1'b0;
        check("reload_evt_valid", 32'(evt_bus.evt_valid), 32'd1);
        check("reload_code", 32'(evt_bus.evt_code), 32'(CResume));
        check("reload_value", 32'(evt_bus.evt_value), 32'h10);
        check("reload_ovf_sticky", 32'(evt_bus.evt_ovf), 32'd1);
        check("reload_state", 32'(state), 32'd1);

        // Reset mid-RUN with a pending record discards it.
        void'(exp_q.pop_front());
        rst_n = 1'b0;
        cyc(8'h33);
        check_cleared("midreset");
        rst_n = 1'b1;
        evt_bus.evt_ready = 1'b1;
        cyc(8'h00);
        cyc(8'h00);
        check("post_reset_state", 32'(state), 32'd0);
        check("post_reset_evt_valid", 32'(evt_bus.evt_valid), 32'd0);

        cyc(8'h00);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 8, giving the count bus width.
REQ-002 The module SHALL expose parameter SAT_HOLD, default 3: the number of unchanged edges at MAX that qualify saturation.
REQ-003 The module SHALL expose parameter STALL_LIMIT, default 16: the number of unchanged edges at a non-MAX value that qualify a stall.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port count, input, WIDTH bits: the value produced by the upstream counter stage, sampled every edge.
REQ-007 The module SHALL have port state, output, 2 bits: the FSM state (IDLE=0, RUN=1, SAT=2, STALL=3).
REQ-008 The module SHALL have port sat_flag, output, 1 bit: high while state==SAT.
REQ-009 The module SHALL have port stall_flag, output, 1 bit: high while state==STALL.
REQ-010 The module SHALL have port change_cnt, output, 16 bits: the number of edges on which count differed from its previous sample, saturating at 16'hFFFF.
REQ-011 The module SHALL have port wrap_cnt, output, 8 bits: the number of MAX->0 transitions, saturating at 8'hFF.
REQ-012 The module SHALL have port evt_valid, output, 1 bit: an event record is available.
REQ-013 The module SHALL have port evt_ready, input, 1 bit: the consumer accepts the event record.
REQ-014 The module SHALL have port evt_code, output, 2 bits: the event code (START=0, SAT=1, STALL=2, RESUME=3).
REQ-015 The module SHALL have port evt_value, output, WIDTH bits: the count value associated with the event.
REQ-016 The module SHALL have port evt_ovf, output, 1 bit: sticky flag, set when an event was dropped.

Function
REQ-017 The module SHALL register prev_q <= count every edge; chg = (count != prev_q); MAX = all-ones.
REQ-018 The module SHALL define same_next = 0 if chg, else min(same_q+1, STALL_LIMIT); same_q <= same_next.
REQ-019 In IDLE on chg, the module SHALL go to RUN and emit START with value count; IDLE SHALL never enter STALL.
REQ-020 In RUN, if count==MAX and same_next>=SAT_HOLD, the module SHALL go to SAT and emit SAT with value MAX.
REQ-021 In RUN, if count!=MAX and same_next>=STALL_LIMIT, the module SHALL go to STALL and emit STALL with value count.
REQ-022 In SAT or STALL on chg, the module SHALL go to RUN and emit RESUME with value count; a MAX->0 change SHALL also increment wrap_cnt.
REQ-023 SAT qualification SHALL have priority over STALL; count held at MAX SHALL never produce STALL.
REQ-024 change_cnt SHALL increment on every chg edge in any state, including the IDLE exit.
REQ-025 State, flag and counter updates SHALL take effect on the same edge that samples the triggering count; the event SHALL be visible on evt_* the following cycle.
REQ-026 The event slot SHALL be one entry deep; a transfer occurs when evt_valid && evt_ready.
REQ-027 On a new event with the slot empty, or with a transfer on the same edge, the module SHALL load the new record and hold evt_valid at 1.
REQ-028 On a new event with the slot full and no transfer, the module SHALL keep the old record, drop the new one, and set evt_ovf.
REQ-029 A transfer with no new event SHALL clear evt_valid; evt_code and evt_value SHALL stay stable while evt_valid=1 and evt_ready=0.

Reset
REQ-030 While rst_n=0 at an edge, all outputs and internal registers SHALL go to 0 (state IDLE, prev_q 0, same_q 0, all flags 0, all counters 0), and count SHALL be ignored on that edge.
REQ-031 Reset asserted mid-operation SHALL discard any pending event and clear evt_ovf; no event SHALL be generated on the first edge after release unless chg.

Structure
REQ-032 Package count_monitor_pkg SHALL hold the state enum, the event-code enum, and the event record typedef (code, value).
REQ-033 The one-entry event slot SHALL be the sub-module count_monitor_evt_slot (push, record, evt_valid/evt_ready, ovf); the FSM and counters SHALL remain in count_monitor.

Verification
REQ-034 Reset, then count=0 for 20 cycles -> state=IDLE, evt_valid=0, change_cnt=0.
REQ-035 Count 0,1,...,255, then held at 255 -> START value 8'h01; SAT value 8'hFF on the 3rd unchanged edge at FF; sat_flag=1; change_cnt=255.
REQ-036 Count held at 8'h40 from RUN for 16 edges -> STALL value 8'h40, stall_flag=1; next count 8'h41 -> RESUME value 8'h41, state=RUN.
REQ-037 From SAT, count FF->00 -> RESUME value 8'h00, wrap_cnt=1, state=RUN.
REQ-038 With evt_ready=0, trigger START then SAT -> evt_code stays START and evt_ovf=1; then pulse evt_ready on the edge of a new RESUME -> slot holds RESUME, evt_valid=1.
REQ-039 Assert rst_n=0 for 1 cycle mid-RUN with evt_valid=1 -> next cycle all outputs 0 and state=IDLE.
